// File: rtl/xgmii_tx_arbiter.sv
// Round-robin, frame-granular arbiter that shares one XGMII TX engine FIFO port between
// N_SRC source FIFOs, with per-source frame counters and sticky stall-timeout flags.
module xgmii_tx_arbiter #(
    parameter int unsigned N_SRC           = 4,
    parameter int unsigned LW              = 8,
    parameter int unsigned WORDS_PER_FRAME = 2,
    parameter int unsigned GAP_CYCLES      = 2,
    parameter int unsigned TIMEOUT         = 256
) (
    input  logic                  xgmii_clk,
    input  logic                  sys_rst,
    input  logic [N_SRC*72-1:0]   src_dout,
    input  logic [N_SRC-1:0]      src_empty,
    input  logic [N_SRC*LW-1:0]   src_level,
    input  logic [N_SRC-1:0]      src_enable,
    output logic [N_SRC-1:0]      src_rd_en,
    output logic [71:0]           dout,
    output logic                  empty,
    input  logic                  rd_en,
    output logic [N_SRC-1:0]      grant,
    output logic                  busy,
    output logic [N_SRC*32-1:0]   frame_cnt,
    output logic [N_SRC-1:0]      timeout_err,
    input  logic                  err_clr
);

    localparam int unsigned IW = $clog2(N_SRC);
    localparam int unsigned TW = $clog2(TIMEOUT);
    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

    state_e              r_state, w_state_nxt;
    logic [N_SRC-1:0]    r_grant, w_grant_nxt;
    logic [IW-1:0]       r_gidx, w_gidx_nxt;
    logic [IW-1:0]       r_rr_ptr, w_rr_ptr_nxt;
    logic [7:0]          r_word_cnt, w_word_cnt_nxt;
    logic [TW-1:0]       r_idle_cnt, w_idle_cnt_nxt;
    logic [GW-1:0]       r_gap_cnt, w_gap_cnt_nxt;
    logic [N_SRC*32-1:0] r_frame_cnt;
    logic [N_SRC-1:0]    r_timeout_err;

    logic [N_SRC-1:0]    w_eligible;
    logic                w_found;
    logic [IW-1:0]       w_win;
    logic                w_in_grant;
    logic                w_accept;
    logic                w_frame_done;
    logic                w_timeout;

    always_comb begin
        w_eligible = '0;
        for (int i = 0; i < N_SRC; i++) begin
            w_eligible[i] = src_enable[i] & ~src_empty[i]
                          & (src_level[i*LW +: LW] >= LW'(WORDS_PER_FRAME));
        end
    end

    // First eligible source at or after rr_ptr, wrapping modulo N_SRC.
    always_comb begin
        int unsigned idx;
        idx     = 0;
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < N_SRC; k++) begin
            idx = (int'(r_rr_ptr) + k) % N_SRC;
            if (!w_found && w_eligible[idx]) begin
                w_found = 1'b1;
                w_win   = IW'(idx);
            end
        end
    end

    assign w_in_grant   = (r_state == StGrant);
    assign w_accept     = w_in_grant & rd_en & ~src_empty[r_gidx];
    assign w_frame_done = w_accept && (r_word_cnt == 8'(WORDS_PER_FRAME - 1));
    assign w_timeout    = w_in_grant && !w_accept && (r_idle_cnt == TW'(TIMEOUT - 1));

    assign empty = w_in_grant ? src_empty[r_gidx] : 1'b1;
    assign dout  = w_in_grant ? src_dout[72*r_gidx +: 72] : 72'd0;

    always_comb begin
        src_rd_en = '0;
        if (w_in_grant) begin
            src_rd_en = r_grant & {N_SRC{rd_en}};
        end
    end

    assign grant       = r_grant;
    assign busy        = (r_state != StIdle);
    assign frame_cnt   = r_frame_cnt;
    assign timeout_err = r_timeout_err;

    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_gidx_nxt     = r_gidx;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_word_cnt_nxt = r_word_cnt;
        w_idle_cnt_nxt = r_idle_cnt;
        w_gap_cnt_nxt  = r_gap_cnt;
        unique case (r_state)
            StIdle: begin
                if (w_found) begin
                    w_state_nxt    = StGrant;
                    w_grant_nxt    = N_SRC'(1) << w_win;
                    w_gidx_nxt     = w_win;
                    w_rr_ptr_nxt   = (w_win == IW'(N_SRC - 1)) ? '0 : w_win + 1'b1;
                    w_word_cnt_nxt = '0;
                    w_idle_cnt_nxt = '0;
                end
            end
            StGrant: begin
                if (w_accept) begin
                    w_word_cnt_nxt = r_word_cnt + 1'b1;
                    w_idle_cnt_nxt = '0;
                end else begin
                    w_idle_cnt_nxt = r_idle_cnt + 1'b1;
                end
                if (w_frame_done) begin
                    w_grant_nxt = '0;
                    if (GAP_CYCLES == 0) begin
                        w_state_nxt = StIdle;
                    end else begin
                        w_state_nxt   = StGap;
                        w_gap_cnt_nxt = GW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
                    end
                end else if (w_timeout) begin
                    w_grant_nxt = '0;
                    w_state_nxt = StIdle;
                end
            end
            StGap: begin
                if (r_gap_cnt == '0) begin
                    w_state_nxt = StIdle;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = StIdle;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge xgmii_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state    <= StIdle;
            r_grant    <= '0;
            r_gidx     <= '0;
            r_rr_ptr   <= '0;
            r_word_cnt <= '0;
            r_idle_cnt <= '0;
            r_gap_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_gidx     <= w_gidx_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_word_cnt <= w_word_cnt_nxt;
            r_idle_cnt <= w_idle_cnt_nxt;
            r_gap_cnt  <= w_gap_cnt_nxt;
        end
    end

    // A timeout in the same cycle as err_clr keeps its flag set.
    always_ff @(posedge xgmii_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_frame_cnt   <= '0;
            r_timeout_err <= '0;
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (w_frame_done && r_grant[i]) begin
                    r_frame_cnt[i*32 +: 32] <= r_frame_cnt[i*32 +: 32] + 32'd1;
                end
            end
            r_timeout_err <= (err_clr ? '0 : r_timeout_err) | (w_timeout ? r_grant : '0);
        end
    end

endmodule

// File: tb/tb_xgmii_tx_arbiter.sv
// Directed bench for xgmii_tx_arbiter: round-robin order, gaps, level skip, timeout,
// async reset mid-frame, and a GAP_CYCLES=0 instance for back-to-back frames and wrap.
module tb_xgmii_tx_arbiter;

    logic         clk;
    logic         rst;
    logic [287:0] src_dout;
    logic [3:0]   src_empty;
    logic [31:0]  src_level;
    logic [3:0]   src_enable;
    logic [3:0]   src_rd_en;
    logic [71:0]  dout;
    logic         empty;
    logic         rd_en;
    logic [3:0]   grant;
    logic         busy;
    logic [127:0] frame_cnt;
    logic [3:0]   timeout_err;
    logic         err_clr;

    logic [3:0]   en2;
    logic [3:0]   src_rd_en2;
    logic [71:0]  dout2;
    logic         empty2;
    logic [3:0]   grant2;
    logic         busy2;
    logic [127:0] frame_cnt2;
    logic [3:0]   timeout_err2;

    int total = 0;
    int bad   = 0;

    xgmii_tx_arbiter dut (
        .xgmii_clk   (clk),
        .sys_rst     (rst),
        .src_dout    (src_dout),
        .src_empty   (src_empty),
        .src_level   (src_level),
        .src_enable  (src_enable),
        .src_rd_en   (src_rd_en),
        .dout        (dout),
        .empty       (empty),
        .rd_en       (rd_en),
        .grant       (grant),
        .busy        (busy),
        .frame_cnt   (frame_cnt),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
    );

    xgmii_tx_arbiter #(.GAP_CYCLES(0)) dut2 (
        .xgmii_clk   (clk),
        .sys_rst     (rst),
        .src_dout    (src_dout),
        .src_empty   (src_empty),
        .src_level   (src_level),
        .src_enable  (en2),
        .src_rd_en   (src_rd_en2),
        .dout        (dout2),
        .empty       (empty2),
        .rd_en       (rd_en),
        .grant       (grant2),
        .busy        (busy2),
        .frame_cnt   (frame_cnt2),
        .timeout_err (timeout_err2),
        .err_clr     (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        src_enable = '0;
        en2        = '0;
        rd_en      = 1'b0;
        err_clr    = 1'b0;
        src_empty  = '0;
        src_level  = {4{8'd4}};
        rst        = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        total++;
        if (grant !== 4'd0 || busy !== 1'b0 || empty !== 1'b1 || src_rd_en !== 4'd0) begin
            bad++;
            $display("FAIL reset_outputs: got grant=%b busy=%b empty=%b rd=%b want 0000 0 1 0000",
                     grant, busy, empty, src_rd_en);
        end
        apply_reset();
        total++;
        if (dout !== 72'd0 || frame_cnt !== 128'd0 || timeout_err !== 4'd0) begin
            bad++;
            $display("FAIL reset_state: got dout=%h fc=%h terr=%b want 0 0 0",
                     dout, frame_cnt, timeout_err);
        end
    endtask

    // Sources 0 and 2 eligible: order 0,2,0,2, two reads per grant, two gap cycles.
    task automatic test_rr_two_sources();
        int w, held, gap;
        logic ok;
        apply_reset();
        src_enable = 4'b0101;
        rd_en      = 1'b1;
        for (int f = 0; f < 4; f++) begin
            w = 0;
            while (grant === 4'd0 && w < 40) begin @(negedge clk); w++; end
            total++;
            if (grant !== (4'd1 << ((f % 2) * 2))) begin
                bad++;
                $display("FAIL rr2_grant[%0d]: got %b want %b", f, grant,
                         4'd1 << ((f % 2) * 2));
            end
            if (f == 3) src_enable = '0;
            held = 0;
            ok   = 1'b1;
            while (grant !== 4'd0 && held < 10) begin
                held++;
                if (src_rd_en !== grant || empty !== 1'b0 ||
                    dout !== src_dout[72*((f % 2) * 2) +: 72]) ok = 1'b0;
                @(negedge clk);
            end
            total++;
            if (held != 2) begin
                bad++;
                $display("FAIL rr2_frame_len[%0d]: got %0d want 2", f, held);
            end
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL rr2_datapath[%0d]: got mismatched rd_en/empty/dout want granted slice", f);
            end
            if (f < 3) begin
                gap = 0;
                while (busy === 1'b1 && grant === 4'd0 && gap < 10) begin
                    gap++;
                    @(negedge clk);
                end
                total++;
                if (gap != 2) begin
                    bad++;
                    $display("FAIL rr2_gap[%0d]: got %0d want 2", f, gap);
                end
            end
        end
        repeat (4) @(negedge clk);
        total++;
        if (frame_cnt[31:0] !== 32'd2 || frame_cnt[95:64] !== 32'd2 ||
            frame_cnt[63:32] !== 32'd0 || frame_cnt[127:96] !== 32'd0) begin
            bad++;
            $display("FAIL rr2_frame_cnt: got %h want 0 2 0 2 (msb..lsb)", frame_cnt);
        end
    endtask

    // All four eligible: order 0,1,2,3,0,1,2,3; rd_en only on the granted bit.
    task automatic test_rr_all_sources();
        int w, held;
        logic ok;
        apply_reset();
        src_enable = 4'b1111;
        rd_en      = 1'b1;
        ok         = 1'b1;
        for (int f = 0; f < 8; f++) begin
            w = 0;
            while (grant === 4'd0 && w < 40) begin
                if (src_rd_en !== 4'd0) ok = 1'b0;
                @(negedge clk);
                w++;
            end
            total++;
            if (grant !== (4'd1 << (f % 4))) begin
                bad++;
                $display("FAIL rr4_grant[%0d]: got %b want %b", f, grant, 4'd1 << (f % 4));
            end
            if (f == 7) src_enable = '0;
            held = 0;
            while (grant !== 4'd0 && held < 10) begin
                held++;
                if (src_rd_en !== grant) ok = 1'b0;
                @(negedge clk);
            end
        end
        repeat (4) @(negedge clk);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL rr4_rd_en_onehot: got rd_en outside granted bit want granted only");
        end
        total++;
        if (frame_cnt !== {4{32'd2}}) begin
            bad++;
            $display("FAIL rr4_frame_cnt: got %h want all 2", frame_cnt);
        end
    endtask

    // Source 1 below the frame threshold is skipped until its level reaches 2.
    task automatic test_level_skip();
        int w;
        apply_reset();
        src_level  = {8'd2, 8'd0, 8'd1, 8'd0};
        src_enable = 4'b1010;
        rd_en      = 1'b1;
        w = 0;
        while (grant === 4'd0 && w < 40) begin @(negedge clk); w++; end
        total++;
        if (grant !== 4'b1000) begin
            bad++;
            $display("FAIL skip_low_level: got %b want 1000", grant);
        end
        src_level[15:8] = 8'd2;
        w = 0;
        while (grant !== 4'd0 && w < 40) begin @(negedge clk); w++; end
        w = 0;
        while (grant === 4'd0 && w < 40) begin @(negedge clk); w++; end
        total++;
        if (grant !== 4'b0010) begin
            bad++;
            $display("FAIL skip_raised_level: got %b want 0010", grant);
        end
        src_enable = '0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_timeout();
        int w, held;
        apply_reset();
        src_enable = 4'b0011;
        rd_en      = 1'b0;
        w = 0;
        while (grant === 4'd0 && w < 40) begin @(negedge clk); w++; end
        total++;
        if (grant !== 4'b0001) begin
            bad++;
            $display("FAIL to_first_grant: got %b want 0001", grant);
        end
        held = 0;
        while (grant !== 4'd0 && held < 400) begin held++; @(negedge clk); end
        total++;
        if (held != 256) begin
            bad++;
            $display("FAIL to_hold_cycles: got %0d want 256", held);
        end
        total++;
        if (timeout_err !== 4'b0001 || frame_cnt[31:0] !== 32'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL to_flag: got terr=%b fc0=%0d busy=%b want 0001 0 0",
                     timeout_err, frame_cnt[31:0], busy);
        end
        rd_en = 1'b1;
        w = 0;
        while (grant === 4'd0 && w < 40) begin @(negedge clk); w++; end
        total++;
        if (grant !== 4'b0010) begin
            bad++;
            $display("FAIL to_next_grant: got %b want 0010", grant);
        end
        src_enable = '0;
        repeat (8) @(negedge clk);
        total++;
        if (frame_cnt[63:32] !== 32'd1 || timeout_err !== 4'b0001) begin
            bad++;
            $display("FAIL to_after_frame: got fc1=%0d terr=%b want 1 0001",
                     frame_cnt[63:32], timeout_err);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        total++;
        if (timeout_err !== 4'b0000) begin
            bad++;
            $display("FAIL to_err_clr: got %b want 0000", timeout_err);
        end
        // err_clr lands exactly in the timeout cycle; the new flag must survive.
        src_enable = 4'b0001;
        rd_en      = 1'b0;
        w = 0;
        while (grant === 4'd0 && w < 40) begin @(negedge clk); w++; end
        held = 0;
        while (grant !== 4'd0 && held < 400) begin
            held++;
            if (held == 256) begin
                err_clr    = 1'b1;
                src_enable = '0;
            end
            @(negedge clk);
        end
        err_clr = 1'b0;
        total++;
        if (held != 256 || timeout_err !== 4'b0001) begin
            bad++;
            $display("FAIL to_set_wins: got held=%0d terr=%b want 256 0001", held, timeout_err);
        end
    endtask

    task automatic test_reset_mid_frame();
        int w;
        apply_reset();
        src_enable = 4'b0101;
        rd_en      = 1'b1;
        w = 0;
        while (grant === 4'd0 && w < 40) begin @(negedge clk); w++; end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if (grant !== 4'd0 || empty !== 1'b1 || src_rd_en !== 4'd0 || busy !== 1'b0 ||
            dout !== 72'd0) begin
            bad++;
            $display("FAIL async_reset: got grant=%b empty=%b rd=%b busy=%b dout=%h want 0 1 0 0 0",
                     grant, empty, src_rd_en, busy, dout);
        end
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (frame_cnt !== 128'd0 || timeout_err !== 4'd0) begin
            bad++;
            $display("FAIL reset_counters: got fc=%h terr=%b want 0 0", frame_cnt, timeout_err);
        end
        w = 0;
        while (grant === 4'd0 && w < 40) begin @(negedge clk); w++; end
        total++;
        if (grant !== 4'b0001) begin
            bad++;
            $display("FAIL reset_rr_restart: got %b want 0001", grant);
        end
        src_enable = '0;
        repeat (8) @(negedge clk);
    endtask

    // GAP_CYCLES=0 instance: 3-cycle frame period, then counter wrap via force.
    task automatic test_back_to_back();
        int cyc, nstart;
        int starts [3];
        logic [3:0] prev;
        apply_reset();
        rd_en  = 1'b1;
        en2    = 4'b0001;
        cyc    = 0;
        nstart = 0;
        prev   = '0;
        while (nstart < 3 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (grant2 !== 4'd0 && prev === 4'd0) begin
                starts[nstart] = cyc;
                nstart++;
            end
            prev = grant2;
        end
        total++;
        if (nstart != 3 || starts[1] - starts[0] != 3 || starts[2] - starts[1] != 3) begin
            bad++;
            $display("FAIL b2b_period: got starts=%0d/%0d,%0d,%0d want 3 starts 3 apart",
                     nstart, starts[0], starts[1], starts[2]);
        end
        en2 = '0;
        repeat (5) @(negedge clk);
        force dut2.r_frame_cnt = {96'd0, 32'hFFFF_FFFF};
        @(negedge clk);
        release dut2.r_frame_cnt;
        @(negedge clk);
        total++;
        if (frame_cnt2[31:0] !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL wrap_preload: got %h want ffffffff", frame_cnt2[31:0]);
        end
        en2 = 4'b0001;
        cyc = 0;
        while (grant2 === 4'd0 && cyc < 40) begin @(negedge clk); cyc++; end
        en2 = '0;
        repeat (5) @(negedge clk);
        total++;
        if (frame_cnt2 !== 128'd0) begin
            bad++;
            $display("FAIL wrap_to_zero: got %h want 0", frame_cnt2);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            src_dout[72*i +: 72] = {8'(8'hA0 + i), 32'hC0DE_0000, 32'(i * 32'h1111_1111)};
        end
        test_reset();
        test_rr_two_sources();
        test_rr_all_sources();
        test_level_skip();
        test_timeout();
        test_reset_mid_frame();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
